// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM states, the program
// start-address table and the default watchdog limit.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_RUN      = 2'd2,
    ST_FINISH   = 2'd3
  } state_t;

  // Upper bound on selectable programs; the table is stored at 32 bits and
  // truncated to the instantiating PC width.
  localparam int MAX_PROGS = 8;

  localparam int TIMEOUT_DEFAULT = 500000;

  localparam logic [31:0] PROG_START_PC [MAX_PROGS] = '{
    32'h000, 32'h040, 32'h100, 32'h180,
    32'h200, 32'h280, 32'h300, 32'h380
  };

  // Start address of a program; indices beyond the table map to address 0.
  function automatic logic [31:0] prog_start_pc(input logic [31:0] idx);
    logic [31:0] pc;
    pc = 32'h0;
    for (int i = 0; i < MAX_PROGS; i++) begin
      if (idx == 32'(i)) pc = PROG_START_PC[i];
    end
    return pc;
  endfunction

endpackage

// File: rtl/run_controller.sv
// Sequences one bounded core run: latch a program, hold the core in reset,
// release it at the program's start PC, then count cycles until HALT or the
// watchdog ends the run. Every output comes straight from a flop.
import run_ctrl_pkg::*;

module run_controller #(
  parameter int NUM_PROGS      = 3,
  parameter int PC_W           = 10,
  parameter int CNT_W          = 20,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int SEL_W         = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [SEL_W-1:0] PROG_SEL,
  input  logic             HALT,
  output logic             CORE_RESET,
  output logic             CORE_EN,
  output logic [PC_W-1:0]  START_PC,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic             BAD_SEL,
  output logic [CNT_W-1:0] CYCLES
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RST_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
  // Counter value during the cycle whose count reaches the watchdog limit.
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_RST   = PC_W'(prog_start_pc(32'd0));

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              bad_sel_q, bad_sel_d;
  logic              core_reset_q, core_reset_d;
  logic              core_en_q, core_en_d;
  logic [PC_W-1:0]   start_pc_q, start_pc_d;
  logic              sel_valid;

  assign sel_valid = ({{(32-SEL_W){1'b0}}, PROG_SEL} < 32'(NUM_PROGS));

  // State and output registers; async reset returns to the idle picture.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      rst_cnt_q    <= '0;
      cycles_q     <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      bad_sel_q    <= 1'b0;
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
      start_pc_q   <= PC_RST;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rst_cnt_q    <= rst_cnt_d;
      cycles_q     <= cycles_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      bad_sel_q    <= bad_sel_d;
      core_reset_q <= core_reset_d;
      core_en_q    <= core_en_d;
      start_pc_q   <= start_pc_d;
    end
  end

  // Next-state logic; the core controls are decoded from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rst_cnt_d = rst_cnt_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    bad_sel_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (START) begin
          if (sel_valid) begin
            state_d   = ST_CORE_RST;
            sel_d     = PROG_SEL;
            rst_cnt_d = RST_LOAD;
            cycles_d  = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
          end else begin
            bad_sel_d = 1'b1;
          end
        end
      end
      ST_CORE_RST: begin
        if (rst_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end
      ST_RUN: begin
        if (cycles_q != CNT_MAX) cycles_d = cycles_q + CNT_W'(1);
        // HALT takes priority so a program finishing on the watchdog cycle
        // is still reported as a clean halt.
        if (HALT) begin
          state_d   = ST_FINISH;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (WD_EN && (cycles_q == WD_LAST)) begin
          state_d   = ST_FINISH;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_CORE_RST);
    core_en_d    = (state_d == ST_RUN);
    start_pc_d   = PC_W'(prog_start_pc(32'(sel_d)));
  end

  assign CORE_RESET = core_reset_q;
  assign CORE_EN    = core_en_q;
  assign START_PC   = start_pc_q;
  assign DONE       = done_q;
  assign TIMEOUT    = timeout_q;
  assign BAD_SEL    = bad_sel_q;
  assign CYCLES     = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: a timeline model (cycles since the accepted
// START) predicts every output each cycle, plus directed literal checks.
module tb_run_controller;

  localparam int NUM_PROGS  = 3;
  localparam int PC_W       = 10;
  localparam int CNT_W      = 20;
  localparam int RST_CYCLES = 2;
  localparam int TMO        = 100;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             halt = 1'b0;
  logic [1:0]       prog_sel = 2'd0;
  logic             core_reset, core_en, done, timeout, bad_sel;
  logic [PC_W-1:0]  start_pc;
  logic [CNT_W-1:0] cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_controller #(
    .NUM_PROGS(NUM_PROGS), .PC_W(PC_W), .CNT_W(CNT_W),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk), .RESET(rst), .START(start), .PROG_SEL(prog_sel), .HALT(halt),
    .CORE_RESET(core_reset), .CORE_EN(core_en), .START_PC(start_pc),
    .DONE(done), .TIMEOUT(timeout), .BAD_SEL(bad_sel), .CYCLES(cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pc_of(input int s);
    case (s)
      0: return 32'h000;
      1: return 32'h040;
      2: return 32'h100;
      default: return 32'h0;
    endcase
  endfunction

  // Model: a run is a timeline counted in edges since acceptance; the first
  // RST_CYCLES cycles are reset hold, after that every cycle is a run cycle.
  bit m_busy, m_done, m_to, m_bad;
  int m_t, m_cycles, m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_to = 0; m_bad = 0;
      m_t = 0; m_cycles = 0; m_sel = 0;
    end else begin
      m_bad = 0;
      if (!m_busy) begin
        if (start) begin
          if (prog_sel < NUM_PROGS) begin
            m_busy = 1; m_t = 0; m_done = 0; m_to = 0; m_cycles = 0;
            m_sel = int'(prog_sel);
          end else begin
            m_bad = 1;
          end
        end
      end else begin
        if (m_t >= RST_CYCLES) begin
          if (m_cycles < CMAX) m_cycles++;
          if (halt) begin
            m_busy = 0; m_done = 1; m_to = 0;
          end else if (m_cycles == TMO) begin
            m_busy = 0; m_done = 1; m_to = 1;
          end
        end
        m_t++;
      end
    end
  end

  // Per-cycle comparison, just after the model and DUT have both updated.
  always @(posedge clk) begin
    #1;
    chk("m_core_reset", 32'(core_reset), 32'(m_busy ? (m_t < RST_CYCLES) : !m_done));
    chk("m_core_en",    32'(core_en),    32'(m_busy && (m_t >= RST_CYCLES)));
    chk("m_done",       32'(done),       32'(m_done));
    chk("m_timeout",    32'(timeout),    32'(m_to));
    chk("m_bad_sel",    32'(bad_sel),    32'(m_bad));
    chk("m_cycles",     32'(cycles),     32'(m_cycles));
    chk("m_start_pc",   32'(start_pc),   pc_of(m_sel));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int sel);
    prog_sel = 2'(sel);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Advance until CORE_EN is seen high at a falling edge, bounded.
  task automatic wait_en(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_en) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_start_pc", 32'(start_pc), 32'h000);
    rst = 1'b0;
    tick(1);

    // Program 1, halt after 37 run cycles
    do_start(1);
    chk("t1_hold1_reset", 32'(core_reset), 32'd1);
    chk("t1_hold1_en", 32'(core_en), 32'd0);
    chk("t1_start_pc", 32'(start_pc), 32'h040);
    tick(1);
    chk("t1_hold2_reset", 32'(core_reset), 32'd1);
    tick(1);
    chk("t1_run_en", 32'(core_en), 32'd1);
    chk("t1_run_reset", 32'(core_reset), 32'd0);
    tick(36);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cycles", 32'(cycles), 32'd37);
    chk("t1_timeout", 32'(timeout), 32'd0);
    chk("t1_en_off", 32'(core_en), 32'd0);
    $display("run 1: sel=1 halt cycles=%0d done=%0d timeout=%0d", cycles, done, timeout);

    // Program 2, watchdog expiry
    do_start(2);
    wait_en("t2_wait_en");
    n = 0;
    while (core_en && n < 300) begin
      n++;
      tick(1);
    end
    chk("t2_en_cycles", 32'(n), 32'd100);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_timeout", 32'(timeout), 32'd1);
    chk("t2_cycles", 32'(cycles), 32'd100);
    chk("t2_start_pc", 32'(start_pc), 32'h100);
    $display("run 2: sel=2 watchdog cycles=%0d done=%0d timeout=%0d", cycles, done, timeout);

    // Program 0, HALT on the watchdog cycle
    do_start(0);
    wait_en("t3_wait_en");
    tick(99);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_timeout", 32'(timeout), 32'd0);
    chk("t3_cycles", 32'(cycles), 32'd100);
    chk("t3_start_pc", 32'(start_pc), 32'h000);
    $display("run 3: sel=0 halt@wd cycles=%0d done=%0d timeout=%0d", cycles, done, timeout);

    // Invalid selector in IDLE
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    prog_sel = 2'd3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_bad_sel", 32'(bad_sel), 32'd1);
    chk("t4_core_reset", 32'(core_reset), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_core_en", 32'(core_en), 32'd0);
    tick(1);
    chk("t4_bad_sel_pulse", 32'(bad_sel), 32'd0);
    chk("t4_still_idle", 32'(core_reset), 32'd1);
    $display("bad sel: sel=3 rejected bad_sel pulse seen");

    // START held through the run, re-accepted in the first FINISH cycle
    prog_sel = 2'd1;
    start = 1'b1;
    tick(1);
    wait_en("t5_wait_en");
    tick(5);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_cycles", 32'(cycles), 32'd6);
    tick(1);
    chk("t5_done_drop", 32'(done), 32'd0);
    chk("t5_cycles_clr", 32'(cycles), 32'd0);
    chk("t5_core_reset", 32'(core_reset), 32'd1);
    start = 1'b0;
    wait_en("t5_wait_en2");
    tick(3);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("t5_second_cycles", 32'(cycles), 32'd4);
    $display("back-to-back: second run cycles=%0d done=%0d", cycles, done);

    // Asynchronous reset in run cycle 20
    do_start(2);
    wait_en("t6_wait_en");
    tick(19);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_core_reset", 32'(core_reset), 32'd1);
    chk("t6_async_core_en", 32'(core_en), 32'd0);
    chk("t6_async_cycles", 32'(cycles), 32'd0);
    chk("t6_async_done", 32'(done), 32'd0);
    chk("t6_async_start_pc", 32'(start_pc), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    tick(150);
    chk("t6_no_done", 32'(done), 32'd0);
    chk("t6_idle", 32'(core_reset), 32'd1);
    $display("async reset: mid-run abort, done=%0d after 150 idle cycles", done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
